m0_reset_power_ctrl: RTL and testbench



---
 rtl/m0_reset_power_ctrl.sv | 105 ++++++++++
 tb/tb_m0_reset_power_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/m0_reset_power_ctrl.sv
// m0_reset_power_ctrl: reset merge/stretch, staggered peripheral reset release, debug power-up ack, sticky reset cause
// Ports: CLK, RSTn (async active-low POR); SYSRESETREQ, EXT_RSTREQ, LOCKUP reset requests;
//   HRESETn core/AHB reset; PRSTn staggered peripheral resets; CDBGPWRUPREQ/ACK debug power handshake;
//   RST_CAUSE sticky causes {ext[N-1:0], lockup, sysresetreq, por}, cleared by RST_CAUSE_CLR.
// Optional: define M0_LOCKUP_RESET_EN to let LOCKUP request a reset and record cause bit2.
module m0_reset_power_ctrl #(
  parameter int NUM_EXT_RST    = 2,
  parameter int NUM_PRST       = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int PWRUP_DELAY    = 8
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   SYSRESETREQ,
  input  logic [NUM_EXT_RST-1:0] EXT_RSTREQ,
  input  logic                   LOCKUP,
  input  logic                   CDBGPWRUPREQ,
  output logic                   CDBGPWRUPACK,
  output logic                   HRESETn,
  output logic [NUM_PRST-1:0]    PRSTn,
  output logic [NUM_EXT_RST+2:0] RST_CAUSE,
  input  logic                   RST_CAUSE_CLR
);
  localparam int CW = $clog2(STRETCH_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int PW = $clog2(PWRUP_DELAY + 2);
  localparam logic [CW-1:0] CMAX = CW'(STRETCH_CYCLES);
  localparam logic [SW-1:0] SMAX = SW'(STAGGER_CYCLES);
  localparam logic [PW-1:0] PMAX = PW'(PWRUP_DELAY + 1);
  typedef enum logic [1:0] {ASSERT, STAGGER, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic hres_d, ack_d, lock_term, req;
  logic [NUM_PRST-1:0] prst_d;
  logic [NUM_EXT_RST+2:0] cause_d;
`ifdef M0_LOCKUP_RESET_EN
  assign lock_term = LOCKUP;
`else
  // port stays referenced but can never request a reset
  assign lock_term = LOCKUP & 1'b0;
`endif
  assign req = SYSRESETREQ | (|EXT_RSTREQ) | lock_term;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    scnt_n  = scnt;
    hres_d  = HRESETn;
    prst_d  = PRSTn;
    if (req) begin
      state_n = ASSERT;
      cnt_n   = CMAX;
      hres_d  = 1'b0;
      prst_d  = '0;
    end else begin
      case (state)
        ASSERT: begin
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_n = STAGGER;
            hres_d  = 1'b1;
            scnt_n  = SMAX;
          end
        end
        STAGGER: begin
          scnt_n = scnt - SW'(1);
          if (scnt == SW'(1)) begin
            // releases proceed bit0 upward by shifting in ones
            prst_d  = (PRSTn << 1) | NUM_PRST'(1);
            scnt_n  = SMAX;
            state_n = prst_d[NUM_PRST-1] ? RUN : STAGGER;
          end
        end
        default: ;
      endcase
    end
  end
  // a new cause set on the same edge as a clear survives the clear
  assign cause_d = (RST_CAUSE_CLR ? '0 : RST_CAUSE) | {EXT_RSTREQ, lock_term, SYSRESETREQ, 1'b0};
  assign pcnt_n  = !CDBGPWRUPREQ ? '0 : (pcnt == PMAX) ? pcnt : pcnt + PW'(1);
  assign ack_d   = CDBGPWRUPREQ && (pcnt_n == PMAX);
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state        <= ASSERT;
      cnt          <= CMAX;
      scnt         <= SMAX;
      pcnt         <= '0;
      HRESETn      <= 1'b0;
      PRSTn        <= '0;
      CDBGPWRUPACK <= 1'b0;
      RST_CAUSE    <= (NUM_EXT_RST+3)'(1);
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      scnt         <= scnt_n;
      pcnt         <= pcnt_n;
      HRESETn      <= hres_d;
      PRSTn        <= prst_d;
      CDBGPWRUPACK <= ack_d;
      RST_CAUSE    <= cause_d;
    end
  end
endmodule

// File: tb/tb_m0_reset_power_ctrl.sv
// tb_m0_reset_power_ctrl: directed pins plus randomized run against an edge-counting reference model
module tb_m0_reset_power_ctrl;
  localparam int NE = 2, NP = 4, ST = 16, SG = 4, PD = 8;
  logic clk = 0, rstn = 0, sysreq = 0, lockup = 0, pwr = 0, clr = 0;
  logic [NE-1:0] ext = '0;
  logic ack, hresetn;
  logic [NP-1:0] prst;
  logic [NE+2:0] cause;
  int passed = 0, total = 0;
  int e = 0, run = 0;
  logic lk_m, req_m;
  logic [NE+2:0] mcause = 1;

  m0_reset_power_ctrl #(.NUM_EXT_RST(NE), .NUM_PRST(NP), .STRETCH_CYCLES(ST),
    .STAGGER_CYCLES(SG), .PWRUP_DELAY(PD)) dut (
    .CLK(clk), .RSTn(rstn), .SYSRESETREQ(sysreq), .EXT_RSTREQ(ext), .LOCKUP(lockup),
    .CDBGPWRUPREQ(pwr), .CDBGPWRUPACK(ack), .HRESETn(hresetn), .PRSTn(prst),
    .RST_CAUSE(cause), .RST_CAUSE_CLR(clr));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // e = edges since the last edge that saw a request (or since POR release)
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e = 0; run = 0; mcause = 1;
    end else begin
`ifdef M0_LOCKUP_RESET_EN
      lk_m = lockup;
`else
      lk_m = 1'b0;
`endif
      req_m = sysreq | (|ext) | lk_m;
      e = req_m ? 0 : (e < 100000 ? e + 1 : e);
      mcause = (clr ? '0 : mcause) | {ext, lk_m, sysreq, 1'b0};
      run = pwr ? (run < 100000 ? run + 1 : run) : 0;
    end
  end

  function automatic logic [NP-1:0] exp_prst(int edges);
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = edges >= ST + SG * (i + 1);
    return r;
  endfunction

  always @(negedge clk) begin
    chk("m_hresetn", hresetn, e >= ST);
    chk("m_prstn", prst, exp_prst(e));
    chk("m_cause", cause, mcause);
    chk("m_ack", ack, run > PD);
  end

  initial begin
    tick(3);
    chk("por_h", hresetn, 0);
    chk("por_prst", prst, 0);
    chk("por_cause", cause, 1);
    chk("por_ack", ack, 0);
    rstn = 1;
    tick(15); chk("h_e15", hresetn, 0);
    tick(1);  chk("h_e16", hresetn, 1); chk("prst_e16", prst, 0);
    tick(3);  chk("prst_e19", prst, 0);
    tick(1);  chk("prst_e20", prst, 4'b0001);
    tick(4);  chk("prst_e24", prst, 4'b0011);
    tick(8);  chk("prst_e32", prst, 4'b1111); chk("cause_por", cause, 5'b00001);
    clr = 1; tick(); clr = 0; chk("cause_clr", cause, 0);
    sysreq = 1; tick(); sysreq = 0;
    chk("sys_h", hresetn, 0); chk("sys_prst", prst, 0); chk("sys_cause", cause, 5'b00010);
    tick(15); chk("sys_h15", hresetn, 0);
    tick(1);  chk("sys_h16", hresetn, 1);
    tick(4);  chk("stg_prst0", prst, 4'b0001);
    ext = 2'b10; tick(); ext = 0;
    chk("ext1_h", hresetn, 0); chk("ext1_prst", prst, 0); chk("ext1_cause", cause, 5'b10010);
    tick(16); chk("ext1_h16", hresetn, 1);
    tick(16); chk("ext1_prst32", prst, 4'b1111);
    ext = 2'b01; tick(); ext = 0;
    repeat (4) begin
      tick(9); chk("ext0_hold", hresetn, 0);
      ext = 2'b01; tick(); ext = 0;
    end
    tick(15); chk("ext0_h15", hresetn, 0);
    tick(1);  chk("ext0_h16", hresetn, 1);
    pwr = 1;
    tick(8); chk("ack_e8", ack, 0);
    tick(1); chk("ack_e9", ack, 1);
    sysreq = 1; tick(); sysreq = 0; chk("ack_sysreq", ack, 1);
    pwr = 0; tick(); chk("ack_drop", ack, 0);
    pwr = 1; tick(4); pwr = 0; tick(); chk("ack_abort", ack, 0);
    tick(10); chk("ack_abort_late", ack, 0);
    tick(40);
    clr = 1; tick(); clr = 0;
    lockup = 1; tick(3); lockup = 0;
`ifdef M0_LOCKUP_RESET_EN
    chk("lock_h", hresetn, 0); chk("lock_cause", cause, 5'b00100);
`else
    chk("lock_h", hresetn, 1); chk("lock_cause", cause, 5'b00000);
`endif
    clr = 1; sysreq = 1; tick(); clr = 0; sysreq = 0;
    chk("clr_set_same", cause, 5'b00010);
    repeat (3000) begin
      sysreq = $urandom_range(199) == 0;
      for (int i = 0; i < NE; i++) ext[i] = $urandom_range(149) == 0;
      lockup = $urandom_range(99) == 0;
      clr = $urandom_range(29) == 0;
      if ($urandom_range(19) == 0) pwr = ~pwr;
      tick();
    end
    sysreq = 0; ext = 0; lockup = 0; clr = 0;
    #2 rstn = 0;
    tick(2);
    chk("rst2_cause", cause, 1); chk("rst2_h", hresetn, 0);
    rstn = 1;
    tick(40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
